// File: rtl/sr_flag_bank.sv
// sr_flag_bank: bank of WIDTH clocked SR flag cells with a selectable S=R=1
// resolution, parallel load, registered edge pulses, popcount and conflict
// reporting.
// Optional feature macro: SR_FLAG_CONFLICT_CNT_EN (saturating conflict counter).
module sr_flag_bank #(
    parameter int                 WIDTH         = 8,
    parameter int                 CONFLICT_MODE = 0,
    parameter logic [WIDTH-1:0]   RESET_VALUE   = {WIDTH{1'b0}}
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [WIDTH-1:0]             S,
    input  logic [WIDTH-1:0]             R,
    input  logic                         load,
    input  logic [WIDTH-1:0]             load_data,
    output logic [WIDTH-1:0]             Qa,
    output logic [WIDTH-1:0]             Qb,
    output logic [WIDTH-1:0]             rise,
    output logic [WIDTH-1:0]             fall,
    output logic [$clog2(WIDTH+1)-1:0]   count,
    output logic                         conflict,
    output logic [7:0]                   conflict_count
);

    localparam int         CW   = $clog2(WIDTH + 1);
    localparam logic [1:0] MODE = 2'(CONFLICT_MODE);

    logic [WIDTH-1:0] qa_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic             conflict_r;
    logic [WIDTH-1:0] qa_next_s;
    logic             conflict_next_s;
    logic [CW-1:0]    count_s;

    // Next flag state: load beats the S/R update, disabled cycles hold.
    always_comb begin
        qa_next_s       = qa_r;
        conflict_next_s = 1'b0;
        if (load) begin
            qa_next_s = load_data;
        end else if (enable) begin
            conflict_next_s = |(S & R);
            for (int i = 0; i < WIDTH; i++) begin
                case ({S[i], R[i]})
                    2'b10:   qa_next_s[i] = 1'b1;
                    2'b01:   qa_next_s[i] = 1'b0;
                    2'b11: begin
                        case (MODE)
                            2'd1:    qa_next_s[i] = 1'b1;
                            2'd2:    qa_next_s[i] = 1'b0;
                            2'd3:    qa_next_s[i] = ~qa_r[i];
                            default: qa_next_s[i] = qa_r[i];
                        endcase
                    end
                    default: qa_next_s[i] = qa_r[i];
                endcase
            end
        end else begin
            qa_next_s = qa_r;
        end
    end

    // Flag register plus registered edge and conflict pulses; reset makes no pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            qa_r       <= RESET_VALUE;
            rise_r     <= {WIDTH{1'b0}};
            fall_r     <= {WIDTH{1'b0}};
            conflict_r <= 1'b0;
        end else begin
            qa_r       <= qa_next_s;
            rise_r     <= qa_next_s & ~qa_r;
            fall_r     <= ~qa_next_s & qa_r;
            conflict_r <= conflict_next_s;
        end
    end

    // Population count of the registered flags only.
    always_comb begin
        count_s = {CW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            count_s = count_s + CW'(qa_r[i]);
        end
    end

`ifdef SR_FLAG_CONFLICT_CNT_EN
    logic [7:0] conflict_cnt_r;

    // Saturating count of conflict pulses, advanced with the pulse it counts.
    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_cnt_r <= 8'd0;
        end else if (conflict_next_s && (conflict_cnt_r != 8'd255)) begin
            conflict_cnt_r <= conflict_cnt_r + 8'd1;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign conflict_count = conflict_cnt_r;
`else
    assign conflict_count = 8'd0;
`endif

    assign Qa       = qa_r;
    assign Qb       = ~qa_r;
    assign rise     = rise_r;
    assign fall     = fall_r;
    assign conflict = conflict_r;
    assign count    = count_s;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Directed self-checking bench for sr_flag_bank: four instances share the
// stimulus, one per S=R=1 resolution mode, all with RESET_VALUE = 8'hA5.
module tb_sr_flag_bank;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] S;
    logic [7:0] R;
    logic       load;
    logic [7:0] load_data;

    logic [7:0] qa   [4];
    logic [7:0] qb   [4];
    logic [7:0] rise [4];
    logic [7:0] fall [4];
    logic [3:0] cnt  [4];
    logic       conf [4];
    logic [7:0] ccnt [4];

    int n_checks = 0;
    int n_fails  = 0;

`ifdef SR_FLAG_CONFLICT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #5 clock = ~clock;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        sr_flag_bank #(
            .WIDTH(8),
            .CONFLICT_MODE(m),
            .RESET_VALUE(8'hA5)
        ) dut (
            .clock(clock),
            .reset(reset),
            .enable(enable),
            .S(S),
            .R(R),
            .load(load),
            .load_data(load_data),
            .Qa(qa[m]),
            .Qb(qb[m]),
            .rise(rise[m]),
            .fall(fall[m]),
            .count(cnt[m]),
            .conflict(conf[m]),
            .conflict_count(ccnt[m])
        );
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; S = 8'h00; R = 8'h00;
        load = 1'b0; load_data = 8'h00;
        #1;

        // Reset state
        step();
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("rst_qa_m%0d", m), 32'(qa[m]), 32'h0000_00A5);
            chk($sformatf("rst_qb_m%0d", m), 32'(qb[m]), 32'h0000_005A);
        end
        chk("rst_count", 32'(cnt[0]), 32'd4);
        chk("rst_rise", 32'(rise[0]), 32'h0);
        chk("rst_fall", 32'(fall[0]), 32'h0);
        chk("rst_conflict", 32'(conf[0]), 32'h0);
        chk("rst_ccnt", 32'(ccnt[0]), 32'h0);

        // Disabled: S ignored for three cycles
        reset = 1'b0; S = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("dis_qa_%0d", k), 32'(qa[0]), 32'h0000_00A5);
            chk($sformatf("dis_rise_%0d", k), 32'(rise[0]), 32'h0);
        end

        // Load 00 from A5: falling pulses on A5 bits
        S = 8'h00; load = 1'b1; load_data = 8'h00;
        step();
        chk("ld0_qa", 32'(qa[0]), 32'h0);
        chk("ld0_fall", 32'(fall[0]), 32'h0000_00A5);
        chk("ld0_count", 32'(cnt[0]), 32'd0);

        // Set low nibble
        load = 1'b0; enable = 1'b1; S = 8'h0F; R = 8'h00;
        step();
        chk("set_qa", 32'(qa[0]), 32'h0000_000F);
        chk("set_rise", 32'(rise[0]), 32'h0000_000F);
        chk("set_count", 32'(cnt[0]), 32'd4);

        // Reset two bits
        S = 8'h00; R = 8'h03;
        step();
        chk("clr_qa", 32'(qa[0]), 32'h0000_000C);
        chk("clr_fall", 32'(fall[0]), 32'h0000_0003);
        chk("clr_rise", 32'(rise[0]), 32'h0);
        chk("clr_count", 32'(cnt[0]), 32'd2);

        // Back to 00 for the per-mode conflict checks
        R = 8'h00; load = 1'b1; load_data = 8'h00;
        step();
        chk("ld1_fall", 32'(fall[0]), 32'h0000_000C);

        // S=R=01 for three cycles in every mode
        load = 1'b0; S = 8'h01; R = 8'h01;
        step();
        chk("c1_m0", 32'(qa[0]), 32'h00);
        chk("c1_m1", 32'(qa[1]), 32'h01);
        chk("c1_m2", 32'(qa[2]), 32'h00);
        chk("c1_m3", 32'(qa[3]), 32'h01);
        chk("c1_m3_rise", 32'(rise[3]), 32'h01);
        for (int m = 0; m < 4; m++) chk($sformatf("c1_conf_m%0d", m), 32'(conf[m]), 32'h1);
        step();
        chk("c2_m1", 32'(qa[1]), 32'h01);
        chk("c2_m3", 32'(qa[3]), 32'h00);
        chk("c2_m3_fall", 32'(fall[3]), 32'h01);
        chk("c2_m1_rise", 32'(rise[1]), 32'h00);
        chk("c2_conf_m3", 32'(conf[3]), 32'h1);
        step();
        chk("c3_m0", 32'(qa[0]), 32'h00);
        chk("c3_m2", 32'(qa[2]), 32'h00);
        chk("c3_m3", 32'(qa[3]), 32'h01);
        chk("c3_m3_rise", 32'(rise[3]), 32'h01);
        chk("c3_conf_m0", 32'(conf[0]), 32'h1);
        chk("c3_ccnt", 32'(ccnt[0]), CNT_EN ? 32'd3 : 32'd0);

        // Load 0F, then load 3C with S=R=FF enabled: load wins, no conflict
        S = 8'h00; R = 8'h00; enable = 1'b0; load = 1'b1; load_data = 8'h0F;
        step();
        for (int m = 0; m < 4; m++) chk($sformatf("ld2_qa_m%0d", m), 32'(qa[m]), 32'h0F);
        S = 8'hFF; R = 8'hFF; enable = 1'b1; load_data = 8'h3C;
        step();
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("ld3_qa_m%0d", m), 32'(qa[m]), 32'h3C);
            chk($sformatf("ld3_conf_m%0d", m), 32'(conf[m]), 32'h0);
        end
        chk("ld3_rise", 32'(rise[0]), 32'h30);
        chk("ld3_fall", 32'(fall[0]), 32'h03);
        chk("ld3_ccnt", 32'(ccnt[0]), CNT_EN ? 32'd3 : 32'd0);

        // Reset overrides load and enable, makes no pulses
        reset = 1'b1; load_data = 8'h00; R = 8'h00;
        step();
        chk("rr_qa", 32'(qa[0]), 32'hA5);
        chk("rr_rise", 32'(rise[0]), 32'h0);
        chk("rr_fall", 32'(fall[0]), 32'h0);
        chk("rr_conf", 32'(conf[0]), 32'h0);
        chk("rr_ccnt", 32'(ccnt[0]), 32'h0);

        // First edge after release takes the update
        reset = 1'b0; load = 1'b0;
        step();
        chk("rel_qa", 32'(qa[0]), 32'hFF);
        chk("rel_qb", 32'(qb[0]), 32'h00);
        chk("rel_rise", 32'(rise[0]), 32'h5A);
        chk("rel_count", 32'(cnt[0]), 32'd8);

        // 300 consecutive conflict cycles
        R = 8'hFF;
        for (int k = 0; k < 300; k++) step();
        chk("long_ccnt", 32'(ccnt[0]), CNT_EN ? 32'd255 : 32'd0);
        chk("long_conf", 32'(conf[0]), 32'h1);
        chk("long_m0", 32'(qa[0]), 32'hFF);
        chk("long_m1", 32'(qa[1]), 32'hFF);
        chk("long_m2", 32'(qa[2]), 32'h00);
        chk("long_m3", 32'(qa[3]), 32'hFF);
        chk("long_m3_rise", 32'(rise[3]), 32'hFF);

        // Disable: no conflict, counter holds
        enable = 1'b0;
        step();
        chk("end_conf", 32'(conf[0]), 32'h0);
        chk("end_ccnt", 32'(ccnt[0]), CNT_EN ? 32'd255 : 32'd0);
        chk("end_m2", 32'(qa[2]), 32'h00);
        chk("end_m2_count", 32'(cnt[2]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
